// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pipe
//  Purpose  : Two-stage valid/ready 32-bit shifter (SLL, SRA, SRL, ROL).
//  Revision : 1.0 - initial release
// ============================================================================
module shift_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_shamt,
    input  logic [1:0]  in_op,
    input  logic [4:0]  in_tag,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_tag
);

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_sra = 2'b01;
    localparam logic [1:0] c_op_srl = 2'b10;

    // One fixed-distance sub-shift; sign is the original operand MSB so SRA
    // stays correct even after earlier sub-shifts.
    function automatic logic [31:0] f_step(input logic [31:0] v,
                                           input logic [1:0]  op,
                                           input logic        sign,
                                           input int unsigned k);
        logic [63:0] w_ext;
        case (op)
            c_op_sll: return v << k;
            c_op_srl: return v >> k;
            c_op_sra: begin
                w_ext = {{32{sign}}, v};
                return 32'(w_ext >> k);
            end
            default: begin
                w_ext = {v, v};
                return 32'(w_ext >> (32 - k));
            end
        endcase
    endfunction

    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    logic [1:0]  r_s1_op;
    logic [4:0]  r_s1_tag;
    logic [2:0]  r_s1_shamt;
    logic        r_s1_sign;

    logic        r_s2_valid;
    logic [31:0] r_s2_data;
    logic [4:0]  r_s2_tag;

    logic        w_s1_en;
    logic        w_s2_en;
    logic [31:0] w_s1_a;
    logic [31:0] w_s1_b;
    logic [31:0] w_s2_a;
    logic [31:0] w_s2_b;
    logic [31:0] w_s2_c;

    assign w_s2_en  = !r_s2_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    // rst_n gating keeps in_ready low while the block is held in reset.
    assign in_ready = w_s1_en && !flush && rst_n;

    assign w_s1_a = in_shamt[4] ? f_step(in_data, in_op, in_data[31], 16) : in_data;
    assign w_s1_b = in_shamt[3] ? f_step(w_s1_a, in_op, in_data[31], 8) : w_s1_a;

    assign w_s2_a = r_s1_shamt[2] ? f_step(r_s1_data, r_s1_op, r_s1_sign, 4) : r_s1_data;
    assign w_s2_b = r_s1_shamt[1] ? f_step(w_s2_a, r_s1_op, r_s1_sign, 2) : w_s2_a;
    assign w_s2_c = r_s1_shamt[0] ? f_step(w_s2_b, r_s1_op, r_s1_sign, 1) : w_s2_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
            r_s1_shamt <= '0;
            r_s1_sign  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            r_s1_data  <= w_s1_b;
            r_s1_op    <= in_op;
            r_s1_tag   <= in_tag;
            r_s1_shamt <= in_shamt[2:0];
            r_s1_sign  <= in_data[31];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_s2_c;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_pipe
//  Purpose  : Directed vector and sequence bench for shift_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  sh;
        logic [31:0] d;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int          n_checks = 0;
    int          n_fail   = 0;
    sb_t         sb[$];
    logic        hold_pending = 1'b0;
    logic [31:0] held_d;
    logic [4:0]  held_t;
    vec_t        vecs[16];

    shift_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic ok, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [4:0] sh,
                                          input logic [1:0] op);
        logic [63:0] t;
        case (op)
            2'b00:   return d << sh;
            2'b01:   return $signed(d) >>> sh;
            2'b10:   return d >> sh;
            default: begin
                t = {d, d} << sh;
                return t[63:32];
            end
        endcase
    endfunction

    // Called at posedge+1: drive, sample at negedge, return at next posedge+1.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] op, input logic [4:0] tag,
                         input logic ordy, input logic fl,
                         input logic [31:0] exp, output logic acc);
        sb_t e;
        in_valid = v; in_data = d; in_shamt = sh; in_op = op; in_tag = tag;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        if (hold_pending)
            chk(out_valid && out_data == held_d && out_tag == held_t,
                "hold_stable", out_data, held_d);
        acc = in_valid && in_ready;
        if (out_valid && out_ready && !fl) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_out", out_data, 32'h0);
            end else begin
                e = sb.pop_front();
                chk(out_data == e.d, "out_data", out_data, e.d);
                chk(out_tag == e.t, "out_tag", {27'd0, out_tag}, {27'd0, e.t});
            end
        end
        hold_pending = out_valid && !out_ready && !fl;
        held_d = out_data;
        held_t = out_tag;
        if (acc) sb.push_back('{d: exp, t: tag});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 32'h0, 5'd0, 2'b00, 5'd0, ordy, 1'b0, 32'h0, acc);
    endtask

    task automatic single_req(input vec_t v, input string nm);
        logic acc;
        cycle(1'b1, v.d, v.sh, v.op, v.tag, 1'b1, 1'b0, v.exp, acc);
        chk(acc, {nm, "_accept"}, {31'd0, acc}, 32'd1);
        chk(!out_valid, {nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        chk(out_valid, {nm, "_lat2"}, {31'd0, out_valid}, 32'd1);
        idle(1'b1);
        chk(sb.size() == 0, {nm, "_drained"}, sb.size(), 32'd0);
    endtask

    initial begin
        logic        acc;
        int          idx;
        int          sent;
        logic [31:0] sd;
        logic [4:0]  ssh;
        logic [1:0]  sop;

        vecs[0]  = '{op: 2'b00, sh: 5'd8,  d: 32'h0000_00FF, tag: 5'd3,  exp: 32'h0000_FF00};
        vecs[1]  = '{op: 2'b01, sh: 5'd31, d: 32'h8000_0000, tag: 5'd5,  exp: 32'hFFFF_FFFF};
        vecs[2]  = '{op: 2'b10, sh: 5'd4,  d: 32'h8000_0000, tag: 5'd6,  exp: 32'h0800_0000};
        vecs[3]  = '{op: 2'b11, sh: 5'd1,  d: 32'h8000_0001, tag: 5'd7,  exp: 32'h0000_0003};
        vecs[4]  = '{op: 2'b00, sh: 5'd0,  d: 32'h1234_5678, tag: 5'd8,  exp: 32'h1234_5678};
        vecs[5]  = '{op: 2'b01, sh: 5'd0,  d: 32'h9234_5678, tag: 5'd9,  exp: 32'h9234_5678};
        vecs[6]  = '{op: 2'b10, sh: 5'd0,  d: 32'h1234_5678, tag: 5'd10, exp: 32'h1234_5678};
        vecs[7]  = '{op: 2'b11, sh: 5'd0,  d: 32'h1234_5678, tag: 5'd11, exp: 32'h1234_5678};
        vecs[8]  = '{op: 2'b11, sh: 5'd16, d: 32'h1234_5678, tag: 5'd12, exp: 32'h5678_1234};
        vecs[9]  = '{op: 2'b01, sh: 5'd4,  d: 32'hF000_0000, tag: 5'd13, exp: 32'hFF00_0000};
        vecs[10] = '{op: 2'b01, sh: 5'd31, d: 32'h7FFF_FFFF, tag: 5'd14, exp: 32'h0000_0000};
        vecs[11] = '{op: 2'b00, sh: 5'd31, d: 32'hFFFF_FFFF, tag: 5'd15, exp: 32'h8000_0000};
        vecs[12] = '{op: 2'b10, sh: 5'd31, d: 32'hFFFF_FFFF, tag: 5'd16, exp: 32'h0000_0001};
        vecs[13] = '{op: 2'b11, sh: 5'd31, d: 32'h0000_000F, tag: 5'd17, exp: 32'h8000_0007};
        vecs[14] = '{op: 2'b11, sh: 5'd13, d: 32'hA5A5_A5A5, tag: 5'd18, exp: 32'hB4B4_B4B4};
        vecs[15] = '{op: 2'b00, sh: 5'd20, d: 32'h1234_5678, tag: 5'd31, exp: 32'h6780_0000};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(!out_valid, "rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk(!in_ready, "rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk(out_data == 32'h0, "rst_out_data", out_data, 32'h0);
        chk(out_tag == 5'd0, "rst_out_tag", {27'd0, out_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk(in_ready, "first_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 16; i++) single_req(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: four SLL-by-1 requests against a stalled output.
        idx = 1;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, idx, 5'd1, 2'b00, 5'(idx), 1'b0, 1'b0, 32'(idx * 2), acc);
            if (acc) idx++;
        end
        chk(idx == 3, "bp_accepted", idx - 1, 32'd2);
        chk(!in_ready, "bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 6 && idx <= 4; c++) begin
            cycle(1'b1, idx, 5'd1, 2'b00, 5'(idx), 1'b1, 1'b0, 32'(idx * 2), acc);
            chk(acc, "bp_no_gap", {31'd0, acc}, 32'd1);
            if (acc) idx++;
        end
        for (int c = 0; c < 10 && sb.size() > 0; c++) idle(1'b1);
        chk(sb.size() == 0, "bp_drained", sb.size(), 32'd0);

        // Streaming with out_ready toggling every cycle.
        sent = 0;
        for (int c = 0; c < 80 && (sent < 8 || sb.size() > 0); c++) begin
            sd  = 32'hC003_0F05 ^ (32'(sent) * 32'h1111_1111);
            ssh = 5'((sent * 7 + 3) % 32);
            sop = 2'(sent % 4);
            if (sent < 8) begin
                cycle(1'b1, sd, ssh, sop, 5'(sent + 20), (c % 2) == 1, 1'b0,
                      model(sd, ssh, sop), acc);
                if (acc) sent++;
            end else begin
                idle((c % 2) == 1);
            end
        end
        chk(sent == 8 && sb.size() == 0, "stream_done", sent, 32'd8);

        // Flush with both stages occupied.
        hold_pending = 1'b0;
        cycle(1'b1, 32'h1, 5'd1, 2'b00, 5'd1, 1'b0, 1'b0, 32'h2, acc);
        cycle(1'b1, 32'h2, 5'd1, 2'b00, 5'd2, 1'b0, 1'b0, 32'h4, acc);
        chk(out_valid, "flush_prefill", {31'd0, out_valid}, 32'd1);
        cycle(1'b1, 32'h3, 5'd1, 2'b00, 5'd3, 1'b0, 1'b1, 32'h6, acc);
        chk(!acc, "flush_blocks_accept", {31'd0, acc}, 32'd0);
        chk(!out_valid, "flush_clears", {31'd0, out_valid}, 32'd0);
        sb.delete();
        idle(1'b1);
        chk(!out_valid, "flush_s1_cleared", {31'd0, out_valid}, 32'd0);
        single_req('{op: 2'b10, sh: 5'd8, d: 32'hDEAD_BEEF, tag: 5'd9, exp: 32'h00DE_ADBE},
                   "post_flush");

        // Asynchronous reset mid-cycle with both stages full.
        cycle(1'b1, 32'h5, 5'd2, 2'b00, 5'd4, 1'b0, 1'b0, 32'h14, acc);
        cycle(1'b1, 32'h6, 5'd2, 2'b00, 5'd5, 1'b0, 1'b0, 32'h18, acc);
        chk(out_valid, "arst_prefill", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk(!out_valid, "arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk(!in_ready, "arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk(out_data == 32'h0, "arst_out_data", out_data, 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        hold_pending = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle(1'b1);
            chk(!out_valid, "arst_stays_empty", {31'd0, out_valid}, 32'd0);
        end
        single_req('{op: 2'b01, sh: 5'd12, d: 32'h8765_4321, tag: 5'd30, exp: 32'hFFF8_7654},
                   "post_arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release sampled on clock.
REQ-003 in_valid  input  1  upstream request valid.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 in_data  input  32  operand to shift.
REQ-006 in_shamt  input  5  shift amount 0..31.
REQ-007 in_op  input  2  00 SLL, 01 SRA, 10 SRL, 11 ROL.
REQ-008 in_tag  input  5  destination register tag, carried unmodified.
REQ-009 flush  input  1  synchronous kill of all in-flight requests.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_data  output  32  shifted result.
REQ-013 out_tag  output  5  tag of the result.

Function
REQ-014 Two-stage pipeline: S1 register holds the partial result after applying shamt[4] (16) and shamt[3] (8); S2 register holds the final result after applying shamt[2:0] (4, 2, 1).
REQ-015 Each stage applies its sub-shift only when the matching shamt bit is 1; otherwise the value passes unchanged.
REQ-016 SLL fills vacated LSBs with 0; SRL fills vacated MSBs with 0; SRA fills vacated MSBs with in_data[31]; ROL reinjects bits shifted out of the MSB end into the LSB end.
REQ-017 S1 carries op, tag, shamt[2:0] and, for SRA, the original sign bit, so S2 needs no upstream inputs.
REQ-018 Accept occurs when in_valid && in_ready; the result appears with out_valid=1 exactly 2 cycles after accept when out_ready stays high.
REQ-019 S2 advances (s2_en) when !s2_valid || out_ready; S1 advances (s1_en) when !s1_valid || s2_en.
REQ-020 in_ready = s1_en && !flush; combinational from out_ready, with no register in the path.
REQ-021 Full throughput: one result per cycle when in_valid and out_ready are held high.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, out_data and out_tag stay stable; at most 2 requests are held, and in_ready=0 when both stages are full.
REQ-023 Results leave in acceptance order; none is dropped or duplicated.
REQ-024 shamt=0 returns in_data unchanged for all ops.
REQ-025 Simultaneous output pop and input accept in the same cycle with both stages full is legal; occupancy stays at 2.
REQ-026 flush=1 clears s1_valid and s2_valid at the next edge, blocks acceptance that cycle, and leaves data registers don't-care; flush has priority over accept and advance.
REQ-027 out_valid is driven directly from s2_valid; out_data and out_tag come from S2 registers (registered outputs).

Reset
REQ-028 While reset=0: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0, in_ready=0.
REQ-029 The first accept is possible in the first cycle after reset is sampled high (in_ready=1 with flush=0).
REQ-030 Reset asserted mid-operation discards all in-flight requests; no result emerges after release.

Verification
REQ-031 SLL 0x000000FF by 8, tag 3, out_ready=1 -> 2 cycles later out_data=0x0000FF00, out_tag=3.
REQ-032 SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL 0x80000000 by 4 -> 0x08000000; ROL 0x80000001 by 1 -> 0x00000003; SLL 0x12345678 by 0 -> 0x12345678.
REQ-033 Issue 4 back-to-back SLL-by-1 requests on 0x1..0x4 with out_ready=0 -> 2 accepted, then in_ready=0; after out_ready=1 -> outputs 0x2, 0x4, 0x6, 0x8 in order with no gaps in acceptance.
REQ-034 Streaming with out_ready toggling every cycle -> each result held stable until popped; tags come out in issue order.
REQ-035 Two requests in flight, flush=1 for 1 cycle -> out_valid=0 on the next cycle; a new request issued afterwards completes normally in 2 cycles.
REQ-036 reset=0 pulsed between clock edges with both stages full -> out_valid drops immediately without waiting for a clock edge, and stays 0 after release until a new accept.
